// File: rtl/bcd_ctrl_pkg.sv
// Shared types, constants and helpers for the BCD counter controller.
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [1:0] bcd2_t;   // [1] tens, [0] units

    // Saturate one digit to the largest legal BCD value
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    // Saturate both digits of a two-digit value
    function automatic bcd2_t bcd2_clamp(input bcd2_t v);
        bcd2_t r;
        r[1] = bcd_clamp(v[1]);
        r[0] = bcd_clamp(v[0]);
        return r;
    endfunction

    // True when both digits are legal BCD
    function automatic logic bcd2_valid(input bcd2_t v);
        return (v[1] <= BCD_MAX) && (v[0] <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with clear, parallel load, enable and wrap pulse.
module bcd2_counter
    import bcd_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  load,
    input  bcd2_t load_value,
    input  logic  en,
    output bcd2_t count,
    output bcd2_t count_inc_c,
    output logic  wrap
);

    logic at_max;

    // Value the counter would take on the next increment
    always_comb begin
        count_inc_c = count;
        at_max      = (count[1] == BCD_MAX) && (count[0] == BCD_MAX);
        if (count[0] == BCD_MAX) begin
            count_inc_c[0] = 4'd0;
            count_inc_c[1] = (count[1] == BCD_MAX) ? 4'd0 : count[1] + 4'd1;
        end else begin
            count_inc_c[0] = count[0] + 4'd1;
        end
    end

    // Count register: clear beats load beats increment
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                count <= '0;
            end else if (load) begin
                count <= load_value;
            end else if (en) begin
                count <= count_inc_c;
                wrap  <= at_max;
            end
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/load controller around a two-digit BCD counter.
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 5
)
(
    input  logic       CLOCK_I,
    input  logic       RESET_I,
    input  logic       START_I,
    input  logic       STOP_I,
    input  logic [1:0] LOAD_REQ_I,
    input  bcd2_t      LOAD_VALUE0_I,
    input  bcd2_t      LOAD_VALUE1_I,
    input  bcd2_t      TARGET_I,
    output bcd2_t      BCD_COUNT_O,
    output logic [1:0] STATE_O,
    output logic [1:0] LOAD_ACK_O,
    output logic       WRAP_O,
    output logic       DONE_O
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    state_t       state;
    state_t       state_next;
    logic         done;
    logic [PW-1:0] presc;
    logic         tick;
    logic         target_hit;
    logic         cnt_clr;
    logic         presc_clr;
    logic         grant_ok;
    logic         grant_sel;
    logic         rr;
    logic [1:0]   ack;
    bcd2_t        load_q;
    bcd2_t        count;
    bcd2_t        count_inc;
    logic         wrap;

    assign tick       = (state == RUN) && (presc == PRESC_LAST);
    assign target_hit = bcd2_valid(TARGET_I) && (count_inc == TARGET_I);

    // State register; DONE flag tracks the state being entered
    always_ff @(posedge CLOCK_I) begin
        if (RESET_I) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE);
        end
    end

    // Next-state logic; STOP has priority over START
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!STOP_I && START_I) state_next = RUN;
            end
            RUN: begin
                if (STOP_I)                 state_next = PAUSE;
                else if (tick && target_hit) state_next = DONE;
            end
            PAUSE: begin
                if (STOP_I)       state_next = IDLE;
                else if (START_I) state_next = RUN;
            end
            DONE: begin
                if (STOP_I)       state_next = IDLE;
                else if (START_I) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM-driven controls for counter, prescaler and arbiter
    always_comb begin
        cnt_clr   = 1'b0;
        presc_clr = 1'b0;
        grant_ok  = 1'b0;
        if ((state == PAUSE && STOP_I) || (state == DONE && !STOP_I && START_I)) begin
            cnt_clr = 1'b1;
        end
        if ((state == IDLE || state == DONE) && state_next == RUN) begin
            presc_clr = 1'b1;
        end
        // Grant only while parked and not mid-acknowledge, so a held request
        // gets a cycle to drop before it can be granted again
        if ((state == IDLE || state == PAUSE) && state_next == state && ack == 2'b00) begin
            grant_ok = 1'b1;
        end
    end

    // Prescaler: runs only in RUN, keeps its phase through PAUSE
    always_ff @(posedge CLOCK_I) begin
        if (RESET_I) begin
            presc <= '0;
        end else if (presc_clr) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

    // Round-robin selection between the two requesters
    always_comb begin
        grant_sel = LOAD_REQ_I[rr] ? rr : ~rr;
    end

    // Grant register; captured value loads on the cycle after the grant
    always_ff @(posedge CLOCK_I) begin
        if (RESET_I) begin
            ack    <= 2'b00;
            rr     <= 1'b0;
            load_q <= '0;
        end else begin
            ack <= 2'b00;
            if (grant_ok && (LOAD_REQ_I != 2'b00)) begin
                ack    <= grant_sel ? 2'b10 : 2'b01;
                rr     <= ~grant_sel;
                load_q <= bcd2_clamp(grant_sel ? LOAD_VALUE1_I : LOAD_VALUE0_I);
            end
        end
    end

    bcd2_counter u_counter (
        .clk         (CLOCK_I),
        .rst         (RESET_I),
        .clr         (cnt_clr),
        .load        (|ack),
        .load_value  (load_q),
        .en          (tick),
        .count       (count),
        .count_inc_c (count_inc),
        .wrap        (wrap)
    );

    assign BCD_COUNT_O = count;
    assign STATE_O     = state;
    assign LOAD_ACK_O  = ack;
    assign WRAP_O      = wrap;
    assign DONE_O      = done;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Self-checking bench for bcd_count_ctrl: directed scenarios plus random run vs model.
module tb_bcd_count_ctrl;

    localparam int unsigned P = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] req;
    logic [7:0] v0;
    logic [7:0] v1;
    logic [7:0] tgt;
    logic [7:0] cnt;
    logic [1:0] st;
    logic [1:0] ack;
    logic       wrap;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_count_ctrl #(.PRESCALE(P)) dut (
        .CLOCK_I       (clk),
        .RESET_I       (rst),
        .START_I       (start),
        .STOP_I        (stop),
        .LOAD_REQ_I    (req),
        .LOAD_VALUE0_I (v0),
        .LOAD_VALUE1_I (v1),
        .TARGET_I      (tgt),
        .BCD_COUNT_O   (cnt),
        .STATE_O       (st),
        .LOAD_ACK_O    (ack),
        .WRAP_O        (wrap),
        .DONE_O        (done)
    );

    // ---------------- behavioural reference model ----------------
    // count as an integer 0..99, state as 0..3, phase = clocks spent in current tick period
    int m_cnt, m_state, m_phase, m_rr, m_ack, m_pend, m_wrap;
    int m_ns, m_nc, m_inc, m_g, m_t;
    bit m_tick, m_hit, m_gok;

    function automatic int clamp9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_state = 0; m_phase = 0; m_rr = 0;
            m_ack = 0; m_pend = 0; m_wrap = 0;
        end else begin
            m_tick = (m_state == 1) && (m_phase == P - 1);
            m_inc  = (m_cnt + 1) % 100;
            m_t    = int'(tgt[7:4]) * 10 + int'(tgt[3:0]);
            m_hit  = m_tick && (tgt[7:4] <= 4'd9) && (tgt[3:0] <= 4'd9) && (m_inc == m_t);
            m_ns   = m_state;
            case (m_state)
                0:       if (!stop && start) m_ns = 1;
                1:       if (stop) m_ns = 2; else if (m_hit) m_ns = 3;
                default: if (stop) m_ns = 0; else if (start) m_ns = 1;
            endcase
            m_nc = m_cnt;
            if (m_tick) m_nc = m_inc;
            if (m_ack != 0) m_nc = m_pend;
            if ((m_state == 2 && stop) || (m_state == 3 && !stop && start)) m_nc = 0;
            m_wrap = (m_tick && m_cnt == 99) ? 1 : 0;
            if (m_state == 1) m_phase = m_tick ? 0 : m_phase + 1;
            if ((m_state == 0 || m_state == 3) && m_ns == 1) m_phase = 0;
            m_gok = (m_state == 0 || m_state == 2) && (m_ns == m_state) && (m_ack == 0);
            if (m_gok && req != 2'b00) begin
                m_g   = req[m_rr] ? m_rr : 1 - m_rr;
                m_ack = (m_g == 1) ? 2 : 1;
                m_rr  = 1 - m_g;
                if (m_g == 1) m_pend = clamp9(int'(v1[7:4])) * 10 + clamp9(int'(v1[3:0]));
                else          m_pend = clamp9(int'(v0[7:4])) * 10 + clamp9(int'(v0[3:0]));
            end else begin
                m_ack = 0;
            end
            m_cnt   = m_nc;
            m_state = m_ns;
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; req = 2'b00;
        step(1);
        rst = 1'b0;
    endtask

    // Load via requester 0 and leave the value showing on the count
    task automatic load0(input logic [7:0] val);
        v0 = val; req = 2'b01;
        step(1);
        req = 2'b00;
        step(1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        pulse_reset();
        n_checks++; if (cnt !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want 00", cnt); end
        n_checks++; if (st !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", st); end
        n_checks++; if (done !== 1'b0 || wrap !== 1'b0) begin n_fail++; $display("FAIL reset_flags: done %b wrap %b want 0 0", done, wrap); end
        tgt = 8'hFF;
        load0(8'h36);
        start = 1'b1; step(1); start = 1'b0;
        step(5);
        n_checks++; if (cnt !== 8'h37) begin n_fail++; $display("FAIL prereset_count: got %h want 37", cnt); end
        rst = 1'b1; step(1); rst = 1'b0;
        n_checks++; if (cnt !== 8'h00 || st !== 2'd0) begin n_fail++; $display("FAIL midrun_reset: count %h state %0d want 00 0", cnt, st); end
        n_checks++; if (done !== 1'b0 || ack !== 2'b00) begin n_fail++; $display("FAIL midrun_reset_flags: done %b ack %b want 0 00", done, ack); end
        v0 = 8'h55; req = 2'b01; step(1);
        n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL prereset_ack: got %b want 01", ack); end
        rst = 1'b1; req = 2'b00; step(1); rst = 1'b0;
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL ack_reset: got %b want 00", ack); end
        step(1);
        n_checks++; if (cnt !== 8'h00) begin n_fail++; $display("FAIL ack_reset_noload: got %h want 00", cnt); end
    endtask

    task automatic test_load();
        pulse_reset();
        v0 = 8'h47; req = 2'b01; step(1);
        n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL load0_ack: got %b want 01", ack); end
        req = 2'b00; step(1);
        n_checks++; if (ack !== 2'b00 || cnt !== 8'h47) begin n_fail++; $display("FAIL load0_count: ack %b count %h want 00 47", ack, cnt); end
        v1 = 8'hC3; req = 2'b10; step(1);
        n_checks++; if (ack !== 2'b10) begin n_fail++; $display("FAIL load1_ack: got %b want 10", ack); end
        req = 2'b00; step(1);
        n_checks++; if (cnt !== 8'h93) begin n_fail++; $display("FAIL load1_clamp: got %h want 93", cnt); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ack [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        logic [7:0] exp_cnt [5] = '{8'h00, 8'h11, 8'h11, 8'h22, 8'h22};
        pulse_reset();
        tgt = 8'hFF; v0 = 8'h11; v1 = 8'h22; req = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step(1);
            n_checks++; if (ack !== exp_ack[i] || cnt !== exp_cnt[i]) begin
                n_fail++; $display("FAIL rr_cycle%0d: ack %b count %h want %b %h", i, ack, cnt, exp_ack[i], exp_cnt[i]);
            end
        end
        req = 2'b00; step(1);
        n_checks++; if (cnt !== 8'h11) begin n_fail++; $display("FAIL rr_last: got %h want 11", cnt); end
        start = 1'b1; step(1); start = 1'b0;
        v0 = 8'h33; req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL run_noack%0d: got %b want 00", i, ack); end
        end
        stop = 1'b1; step(1); stop = 1'b0;
        n_checks++; if (st !== 2'd2 || ack !== 2'b00) begin n_fail++; $display("FAIL stop_pause: state %0d ack %b want 2 00", st, ack); end
        step(1);
        n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL pause_ack: got %b want 01", ack); end
        req = 2'b00; step(1);
        n_checks++; if (cnt !== 8'h33 || st !== 2'd2) begin n_fail++; $display("FAIL pause_load: count %h state %0d want 33 2", cnt, st); end
    endtask

    task automatic test_target_wrap();
        pulse_reset();
        tgt = 8'hFF;
        load0(8'h98);
        tgt = 8'h05;
        start = 1'b1; step(1); start = 1'b0;
        step(4);
        n_checks++; if (cnt !== 8'h98) begin n_fail++; $display("FAIL first_inc_early: got %h want 98", cnt); end
        step(1);
        n_checks++; if (cnt !== 8'h99 || wrap !== 1'b0) begin n_fail++; $display("FAIL inc_99: count %h wrap %b want 99 0", cnt, wrap); end
        step(5);
        n_checks++; if (cnt !== 8'h00 || wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_00: count %h wrap %b want 00 1", cnt, wrap); end
        step(1);
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse: got %b want 0", wrap); end
        step(24);
        n_checks++; if (cnt !== 8'h05 || st !== 2'd3 || done !== 1'b1) begin n_fail++; $display("FAIL done_05: count %h state %0d done %b want 05 3 1", cnt, st, done); end
        step(10);
        n_checks++; if (cnt !== 8'h05 || st !== 2'd3) begin n_fail++; $display("FAIL done_hold: count %h state %0d want 05 3", cnt, st); end
        start = 1'b1; step(1); start = 1'b0;
        n_checks++; if (cnt !== 8'h00 || st !== 2'd1 || done !== 1'b0) begin n_fail++; $display("FAIL done_restart: count %h state %0d done %b want 00 1 0", cnt, st, done); end
    endtask

    task automatic test_pause();
        pulse_reset();
        tgt = 8'hFF;
        start = 1'b1; step(1); start = 1'b0;
        step(5);
        n_checks++; if (cnt !== 8'h01) begin n_fail++; $display("FAIL pause_tick1: got %h want 01", cnt); end
        step(1); stop = 1'b1; step(1); stop = 1'b0;
        n_checks++; if (st !== 2'd2 || cnt !== 8'h01) begin n_fail++; $display("FAIL pause_enter: state %0d count %h want 2 01", st, cnt); end
        step(10);
        n_checks++; if (st !== 2'd2 || cnt !== 8'h01) begin n_fail++; $display("FAIL pause_frozen: state %0d count %h want 2 01", st, cnt); end
        start = 1'b1; step(1); start = 1'b0;
        n_checks++; if (st !== 2'd1) begin n_fail++; $display("FAIL resume: got %0d want 1", st); end
        step(2);
        n_checks++; if (cnt !== 8'h01) begin n_fail++; $display("FAIL resume_early: got %h want 01", cnt); end
        step(1);
        n_checks++; if (cnt !== 8'h02) begin n_fail++; $display("FAIL resume_partial: got %h want 02", cnt); end
        start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
        n_checks++; if (st !== 2'd2 || cnt !== 8'h02) begin n_fail++; $display("FAIL both_cmd: state %0d count %h want 2 02", st, cnt); end
        stop = 1'b1; step(1); stop = 1'b0;
        n_checks++; if (st !== 2'd0 || cnt !== 8'h00) begin n_fail++; $display("FAIL pause_stop: state %0d count %h want 0 00", st, cnt); end
    endtask

    task automatic test_no_early_done();
        int hits;
        pulse_reset();
        tgt = 8'hFF;
        load0(8'h20);
        tgt = 8'h20;
        start = 1'b1; step(1); start = 1'b0;
        hits = 0;
        for (int i = 0; i < 99 * P; i++) begin
            step(1);
            if (done) hits++;
        end
        n_checks++; if (hits !== 0 || cnt !== 8'h19) begin n_fail++; $display("FAIL early_done: hits %0d count %h want 0 19", hits, cnt); end
        step(P);
        n_checks++; if (cnt !== 8'h20 || st !== 2'd3) begin n_fail++; $display("FAIL late_done: count %h state %0d want 20 3", cnt, st); end
        pulse_reset();
        tgt = 8'hA0;
        start = 1'b1; step(1); start = 1'b0;
        hits = 0;
        for (int i = 0; i < 220 * P; i++) begin
            step(1);
            if (done) hits++;
        end
        n_checks++; if (hits !== 0 || st !== 2'd1) begin n_fail++; $display("FAIL bad_target: hits %0d state %0d want 0 1", hits, st); end
    endtask

    task automatic test_random();
        logic [7:0] exp_cnt;
        pulse_reset();
        tgt = 8'h37;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            step(1);
            exp_cnt = {4'(m_cnt / 10), 4'(m_cnt % 10)};
            n_checks++; if (cnt !== exp_cnt) begin n_fail++; $display("FAIL rnd_count@%0d: got %h want %h", cyc, cnt, exp_cnt); end
            n_checks++; if (st !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state@%0d: got %0d want %0d", cyc, st, m_state); end
            n_checks++; if (ack !== 2'(m_ack)) begin n_fail++; $display("FAIL rnd_ack@%0d: got %b want %0d", cyc, ack, m_ack); end
            n_checks++; if (wrap !== 1'(m_wrap)) begin n_fail++; $display("FAIL rnd_wrap@%0d: got %b want %0d", cyc, wrap, m_wrap); end
            n_checks++; if (done !== (m_state == 3)) begin n_fail++; $display("FAIL rnd_done@%0d: got %b want %0d", cyc, done, m_state == 3); end
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            if (cyc % 60 == 0) tgt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if (req[0] && ack[0]) req[0] = 1'b0;
            else if (!req[0] && $urandom_range(0, 5) == 0) begin req[0] = 1'b1; v0 = 8'($urandom); end
            if (req[1] && ack[1]) req[1] = 1'b0;
            else if (!req[1] && $urandom_range(0, 5) == 0) begin req[1] = 1'b1; v1 = 8'($urandom); end
        end
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; req = 2'b00;
        v0 = 8'h00; v1 = 8'h00; tgt = 8'hFF;
        step(2);
        rst = 1'b0;
        test_reset();
        test_load();
        test_round_robin();
        test_target_wrap();
        test_pause();
        test_no_early_done();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_count_ctrl.md
# bcd_count_ctrl

Run/pause/load controller for the 2-digit BCD counter, with the counter datapath instantiated inside. It divides the system clock into count ticks and sequences counting through a start/stop state machine. It round-robin arbitrates parallel-load requests from two sources, flags wrap-around and stops on a programmable two-digit target. It sits between the board's push-button/switch logic and the 7-segment display path.

## Interface
- PRESCALE, default 5: system clocks per count tick, ≥2.
- CLOCK_I  in  1  system clock; all logic on rising edge.
- RESET_I  in  1  synchronous, active-high reset.
- START_I  in  1  level-sampled start/resume command.
- STOP_I  in  1  level-sampled stop/clear command.
- LOAD_REQ_I  in  2  load request per requester; held until acked.
- LOAD_VALUE0_I  in  [3:0][1:0]  requester 0 load digits; [1] tens, [0] units.
- LOAD_VALUE1_I  in  [3:0][1:0]  requester 1 load digits.
- TARGET_I  in  [3:0][1:0]  stop value.
- BCD_COUNT_O  out  [3:0][1:0]  current count.
- STATE_O  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- LOAD_ACK_O  out  2  one-cycle grant pulse per requester.
- WRAP_O  out  1  one-cycle pulse on the 99→00 increment.
- DONE_O  out  1  high while in DONE.

## Operation
- States and transitions, evaluated each edge; STOP_I wins over START_I when both are high:
  - IDLE: START→RUN; count held.
  - RUN: STOP→PAUSE; an increment landing on TARGET→DONE.
  - PAUSE: STOP→IDLE with count cleared to 00; START→RUN.
  - DONE: START→RUN with count cleared to 00; STOP→IDLE, count unchanged.
- Prescaler counts 0..PRESCALE-1 only in RUN.
  - Tick fires when it equals PRESCALE-1; it then returns to 0.
  - Cleared on entry to RUN from IDLE or DONE.
  - Retains its value through PAUSE, so resume continues the partial period.
- Increment on tick: units 0..9.
  - At units 9, units becomes 0 and tens increments.
  - Tens at 9 with units at 9 wraps the count to 00 and pulses WRAP_O.
- Target match is checked only on the value produced by an increment.
  - A count already equal to TARGET at START does not trigger DONE.
  - A TARGET digit >9 never matches.
  - On a match, WRAP_O and the DONE entry can coincide (TARGET=00).
- Load arbitration:
  - Grants only in IDLE or PAUSE, at most one per cycle.
  - Round-robin pointer: after requester n is granted, the other requester has priority next.
  - Requests in RUN or DONE stay pending, unacked.
  - A grant loads the selected value; any digit >9 is clamped to 9.
- Reset values: count 00, IDLE, prescaler 0, RR pointer favours requester 0, all pulse outputs 0, DONE_O 0.

## Timing
- Command sampled at edge k: STATE_O changes at k. The first increment after entering RUN at k occurs at edge k+PRESCALE.
- Load: request high before edge k in IDLE/PAUSE. LOAD_ACK_O is high during cycle k..k+1, and BCD_COUNT_O shows the loaded value after edge k+1. The requester deasserts on the ack.
- A requester still high after its ack re-competes and may be granted again two cycles later.
- WRAP_O and the DONE transition are registered with the increment that causes them.
- RESET_I high at any edge, including mid-RUN or during an ack, forces all reset values at that edge. No pending state survives.

## Structure
- Shared package bcd_ctrl_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - BCD_MAX = 4'd9;
  - bcd_digit_t typedef and a two-digit array type;
  - the clamp function.
- Sub-module bcd2_counter: 2-digit BCD counter with enable, synchronous clear, parallel load and wrap output.
- FSM, prescaler and arbiter live in bcd_count_ctrl.

## Test plan
All scenarios run with PRESCALE=5.
1. Assert reset mid-count at 37 in RUN → next edge: count 00, IDLE, DONE_O=0, LOAD_ACK_O=00.
2. IDLE; request 0 with value {4,7} → LOAD_ACK_O=01 for one cycle, count 47 the next cycle. Then request 1 with {12,3} → count 93 (tens clamped).
3. Both requests high continuously in IDLE → acks alternate 01,10,01; count equals the last granted value. Requests raised in RUN → no ack until STOP gives PAUSE.
4. Load 98, TARGET 05, START:
   - 99 at +5 cycles;
   - 00 with WRAP_O pulse at +10;
   - 05 and DONE at +35, then count held.
   - START in DONE → count 00, RUN.
5. RUN, STOP 2 cycles after a tick → PAUSE, count frozen. START → next increment 3 cycles later. START and STOP together in RUN → PAUSE. STOP in PAUSE → IDLE, count 00.
6. Count 20, TARGET 20, START → no DONE until the next wrap back to 20. TARGET {10,0} → never DONE.
